data_fifo_burst_ctrl: RTL and testbench

- Parametrised successor to the single-channel data FIFO controller; sits between the AXI-Stream data source and the NVMe/DDR write engine.
- Buffers s_axis beats in an internal synchronous FIFO.
- Serves whole bursts on request: the burst engine asks for rd_len beats, and the block waits until that many words are stored.
- It then streams exactly rd_len beats on m_axis with tlast and signals completion, replacing pop-by-pop draining.

---
 rtl/data_fifo_burst_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_data_fifo_burst_ctrl.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_fifo_burst_ctrl.sv
// Purpose  : AXI-Stream word FIFO that hands out whole bursts of rd_len beats on request.
// Latency  : rd_req to first m_axis_tvalid is 2 cycles when enough words are stored. The last handshake to rd_done is 1 cycle.
// Backpress: s_axis_tready is a registered (count < DEPTH) flag. m_axis holds tvalid/tdata/tlast until tready.
//
// Ports:
//   aclk, aresetn               clock, asynchronous active-low reset
//   s_axis_tvalid/tready/tdata  input beat stream
//   rd_req, rd_len              burst request (sampled only when idle), burst length
//   rd_busy, rd_done, rd_err    burst status (done/err are one-cycle pulses)
//   m_axis_tvalid/tready/tdata/tlast  output burst stream
//   data_count, fifo_empty      occupancy, including the output register
//   prog_full                   programmable full flag, present when DATA_FIFO_PROG_FULL_EN is defined (otherwise tied 0)
//
// Optional feature macro: DATA_FIFO_PROG_FULL_EN
module data_fifo_burst_ctrl #(
  parameter int DATA_WIDTH       = 128,
  parameter int DEPTH_LOG2       = 14,
  parameter int LEN_WIDTH        = 9,
  parameter int PROG_FULL_THRESH = 16300,
  parameter int PROG_FULL_HYST   = 64
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  rd_req,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [DEPTH_LOG2:0]   data_count,
  output logic                  fifo_empty,
  output logic                  prog_full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  // Reject threshold settings whose clear level would underflow or whose set level can never be reached.
  if ((PROG_FULL_HYST < 0) || (PROG_FULL_HYST > PROG_FULL_THRESH) || (PROG_FULL_THRESH > DEPTH)) begin : g_bad_prog_full_cfg
    $error("data_fifo_burst_ctrl: invalid PROG_FULL_THRESH/PROG_FULL_HYST");
  end

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_WAIT = 4'b0010,
    S_READ = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic                   err_q, err_d;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic [DEPTH_LOG2:0]    mem_cnt;
  logic                   out_vld_q;
  logic [DATA_WIDTH-1:0]  out_dat_q;
  logic                   tready_q;

  logic                   wr_en;
  logic                   pop;
  logic                   rd_en;
  logic                   last_beat;

  assign wr_en     = s_axis_tvalid && tready_q;
  assign pop       = (state_q == S_READ) && out_vld_q && m_axis_tready;
  assign last_beat = (beat_q == (len_q - LEN_ONE));

  // Words still in the RAM are the total count minus the one held in the output register.
  assign mem_cnt = count_q - {{DEPTH_LOG2{1'b0}}, out_vld_q};
  // Refill the output register whenever it is empty or being drained this cycle.
  assign rd_en   = (mem_cnt != '0) && (!out_vld_q || pop);

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // RAM: simple dual port, registered read feeding the output register directly.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= s_axis_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (rd_en) begin
      out_dat_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_vld_q <= 1'b0;
      tready_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (rd_en)    out_vld_q <= 1'b1;
      else if (pop) out_vld_q <= 1'b0;
      count_q  <= count_d;
      // Ready follows the registered count, so a read at full frees space only from the next cycle.
      tready_q <= (count_d < FULL_CNT);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beat_d        = beat_q;
    err_d         = err_q;
    rd_busy       = 1'b1;
    rd_done       = 1'b0;
    rd_err        = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rd_busy = 1'b0;
        if (rd_req) begin
          beat_d = '0;
          if (rd_len != '0) begin
            len_d   = rd_len;
            err_d   = 1'b0;
            state_d = S_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        // Start only once the whole burst is stored; the burst then never stalls on empty.
        if (count_q >= {{(DEPTH_LOG2+1-LEN_WIDTH){1'b0}}, len_q}) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        m_axis_tvalid = out_vld_q;
        m_axis_tlast  = out_vld_q && last_beat;
        if (pop) begin
          beat_d = beat_q + LEN_ONE;
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE: begin
        rd_done = 1'b1;
        rd_err  = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tdata  = out_dat_q;
  assign data_count    = count_q;
  assign fifo_empty    = (count_q == '0);

`ifdef DATA_FIFO_PROG_FULL_EN
  localparam logic [DEPTH_LOG2:0] PF_SET = (DEPTH_LOG2+1)'(PROG_FULL_THRESH);
  localparam logic [DEPTH_LOG2:0] PF_CLR = (DEPTH_LOG2+1)'(PROG_FULL_THRESH - PROG_FULL_HYST);

  logic pf_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pf_q <= 1'b0;
    end else if (count_q >= PF_SET) begin
      pf_q <= 1'b1;
    end else if (count_q < PF_CLR) begin
      pf_q <= 1'b0;
    end
  end

  assign prog_full = pf_q;
`else
  assign prog_full = 1'b0;
`endif

endmodule

// File: tb/tb_data_fifo_burst_ctrl.sv
// Bench for data_fifo_burst_ctrl: scenario tasks drive stimulus and check inline.
// A negedge monitor keeps a data scoreboard and an occupancy model.
`timescale 1ns/1ps
module tb_data_fifo_burst_ctrl;
  localparam int DW    = 128;
  localparam int DL2   = 14;
  localparam int LW    = 9;
  localparam int DEPTH = 1 << DL2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          rd_req = 1'b0;
  logic [LW-1:0] rd_len = '0;
  logic          rd_busy, rd_done, rd_err;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [DL2:0]  data_count;
  logic          fifo_empty, prog_full;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  int            model_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  logic          prev_last = 1'b0;
  logic [31:0]   seq = 32'h1000;

  always #5 aclk = ~aclk;

  data_fifo_burst_ctrl dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .rd_req(rd_req), .rd_len(rd_len), .rd_busy(rd_busy), .rd_done(rd_done), .rd_err(rd_err),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .data_count(data_count), .fifo_empty(fifo_empty), .prog_full(prog_full)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard: inputs only change just after a rising edge, so the values seen here are the ones the next edge samples.
  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_q.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      vectors++;
      if (int'(data_count) != model_cnt || fifo_empty !== (model_cnt == 0)) begin
        miscompares++;
        $display("FAIL occupancy: data_count=%0d fifo_empty=%b, expected %0d/%b", data_count, fifo_empty, model_cnt, model_cnt == 0);
      end
      if (prev_stall) begin
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_dat || m_axis_tlast !== prev_last) begin
          miscompares++;
          $display("FAIL stall_hold: tvalid=%b tdata=%h tlast=%b, expected 1/%h/%b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_dat, prev_last);
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back(s_axis_tdata);
        model_cnt++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL data_order: got %h, expected no beat (scoreboard empty)", m_axis_tdata);
        end else begin
          if (m_axis_tdata !== exp_q[0]) begin
            miscompares++;
            $display("FAIL data_order: got %h, expected %h", m_axis_tdata, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        model_cnt--;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_dat   = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    vectors++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || rd_busy !== 1'b0 ||
        rd_done !== 1'b0 || rd_err !== 1'b0 || data_count !== '0 || fifo_empty !== 1'b1 || prog_full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: tready=%b tvalid=%b tlast=%b busy=%b done=%b err=%b count=%0d empty=%b pf=%b, expected 0 0 0 0 0 0 0 1 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, rd_busy, rd_done, rd_err, data_count, fifo_empty, prog_full);
    end
    aresetn = 1'b1;
    tick();
    vectors++;
    if (s_axis_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: tready=%b, expected 1", s_axis_tready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) begin
      s_axis_tdata  = DW'(i);
      s_axis_tvalid = 1'b1;
      tick();
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    rd_len = LW'(8);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    vectors++;
    if (rd_busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_wait: busy=%b tvalid=%b, expected 1/0", rd_busy, m_axis_tvalid);
    end
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_req_latency: tvalid=%b two cycles after rd_req, expected 1", m_axis_tvalid);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== DW'(i) || m_axis_tlast !== (i == 7)) begin
        miscompares++;
        $display("FAIL basic_beat%0d: tvalid=%b tdata=%h tlast=%b, expected 1/%h/%b", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, DW'(i), i == 7);
      end
      tick();
    end
    vectors++;
    if (rd_done !== 1'b1 || rd_err !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: done=%b err=%b tvalid=%b, expected 1/0/0", rd_done, rd_err, m_axis_tvalid);
    end
    tick();
    vectors++;
    if (rd_done !== 1'b0 || rd_busy !== 1'b0 || data_count !== '0 || fifo_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_idle: done=%b busy=%b count=%0d empty=%b, expected 0/0/0/1", rd_done, rd_busy, data_count, fifo_empty);
    end
    m_axis_tready = 1'b0;
  endtask

  task automatic test_wait();
    int g;
    for (int i = 0; i < 2; i++) begin
      s_axis_tdata = DW'(32'h100 + i); s_axis_tvalid = 1'b1; tick();
    end
    s_axis_tvalid = 1'b0;
    rd_len = LW'(4);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (m_axis_tvalid !== 1'b0 || rd_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL wait_hold: cycle %0d tvalid=%b busy=%b, expected 0/1", i, m_axis_tvalid, rd_busy);
      end
      tick();
    end
    for (int i = 2; i < 4; i++) begin
      s_axis_tdata = DW'(32'h100 + i); s_axis_tvalid = 1'b1; tick();
    end
    s_axis_tvalid = 1'b0;
    g = 0;
    while (m_axis_tvalid !== 1'b1 && g < 20) begin tick(); g++; end
    vectors++;
    if (m_axis_tvalid !== 1'b1 || data_count !== (DL2+1)'(4)) begin
      miscompares++;
      $display("FAIL wait_release: tvalid=%b count=%0d, expected 1/4", m_axis_tvalid, data_count);
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== DW'(32'h100 + i) || m_axis_tlast !== (i == 3)) begin
        miscompares++;
        $display("FAIL wait_beat%0d: tvalid=%b tdata=%h tlast=%b, expected 1/%h/%b", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, DW'(32'h100 + i), i == 3);
      end
      tick();
    end
    m_axis_tready = 1'b0;
    vectors++;
    if (rd_done !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_done: done=%b, expected 1", rd_done);
    end
    tick();
  endtask

  task automatic test_zero_len();
    logic [DL2:0] c;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = DW'(32'h200 + i); s_axis_tvalid = 1'b1; tick();
    end
    s_axis_tvalid = 1'b0;
    c = data_count;
    rd_len = '0;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    vectors++;
    if (rd_done !== 1'b1 || rd_err !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_pulse: done=%b err=%b tvalid=%b, expected 1/1/0", rd_done, rd_err, m_axis_tvalid);
    end
    tick();
    vectors++;
    if (rd_done !== 1'b0 || rd_err !== 1'b0 || rd_busy !== 1'b0 || m_axis_tvalid !== 1'b0 || data_count !== c) begin
      miscompares++;
      $display("FAIL zero_len_after: done=%b err=%b busy=%b tvalid=%b count=%0d, expected 0/0/0/0/%0d", rd_done, rd_err, rd_busy, m_axis_tvalid, data_count, c);
    end
  endtask

  task automatic test_random_burst();
    fork
      begin
        int acc;
        int g;
        acc = 0;
        g = 0;
        while (acc < 40 && g < 1000) begin
          s_axis_tdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
          s_axis_tvalid = 1'($urandom_range(0, 1));
          if (s_axis_tvalid && s_axis_tready) acc++;
          tick();
          g++;
        end
        s_axis_tvalid = 1'b0;
      end
      begin
        int n;
        int g;
        n = 0;
        g = 0;
        rd_len = LW'(16);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        while (n < 16 && g < 2000) begin
          m_axis_tready = 1'($urandom_range(0, 1));
          if (m_axis_tvalid && m_axis_tready) begin
            vectors++;
            if (m_axis_tlast !== (n == 15)) begin
              miscompares++;
              $display("FAIL rand_tlast: beat %0d tlast=%b, expected %b", n, m_axis_tlast, n == 15);
            end
            n++;
          end
          tick();
          g++;
        end
        m_axis_tready = 1'b0;
        vectors++;
        if (n != 16 || rd_done !== 1'b1) begin
          miscompares++;
          $display("FAIL rand_burst_end: beats=%0d done=%b, expected 16/1", n, rd_done);
        end
      end
    join
    tick();
  endtask

  task automatic test_full();
    int g;
    g = 0;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready === 1'b1 && g < DEPTH + 100) begin
      s_axis_tdata = DW'(seq);
      seq++;
      tick();
      g++;
    end
    vectors++;
    if (int'(data_count) != DEPTH || s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_level: count=%0d tready=%b, expected %0d/0", data_count, s_axis_tready, DEPTH);
    end
`ifdef DATA_FIFO_PROG_FULL_EN
    vectors++;
    if (prog_full !== 1'b1) begin
      miscompares++;
      $display("FAIL full_prog_full: prog_full=%b, expected 1", prog_full);
    end
`else
    vectors++;
    if (prog_full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_prog_full: prog_full=%b, expected 0", prog_full);
    end
`endif
    repeat (3) tick();
    rd_len = LW'(1);
    rd_req = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    // This edge performs the read while a write is still offered at full.
    vectors++;
    if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0 || int'(data_count) != DEPTH) begin
      miscompares++;
      $display("FAIL full_read_setup: tvalid=%b tready=%b count=%0d, expected 1/0/%0d", m_axis_tvalid, s_axis_tready, data_count, DEPTH);
    end
    tick();
    vectors++;
    if (int'(data_count) != DEPTH - 1 || s_axis_tready !== 1'b1 || rd_done !== 1'b1) begin
      miscompares++;
      $display("FAIL full_after_read: count=%0d tready=%b done=%b, expected %0d/1/1", data_count, s_axis_tready, rd_done, DEPTH - 1);
    end
    s_axis_tdata = DW'(seq);
    seq++;
    tick();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    vectors++;
    if (int'(data_count) != DEPTH || s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_refill: count=%0d tready=%b, expected %0d/0", data_count, s_axis_tready, DEPTH);
    end
  endtask

  task automatic test_reset_mid_burst();
    rd_len = LW'(100);
    rd_req = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (6) tick();
    vectors++;
    if (m_axis_tvalid !== 1'b1 || rd_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midburst_active: tvalid=%b busy=%b, expected 1/1", m_axis_tvalid, rd_busy);
    end
    aresetn = 1'b0;
    #1;
    vectors++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || rd_busy !== 1'b0 ||
        rd_done !== 1'b0 || rd_err !== 1'b0 || data_count !== '0 || fifo_empty !== 1'b1 || prog_full !== 1'b0) begin
      miscompares++;
      $display("FAIL midburst_reset: tready=%b tvalid=%b tlast=%b busy=%b done=%b err=%b count=%0d empty=%b pf=%b, expected 0 0 0 0 0 0 0 1 0",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, rd_busy, rd_done, rd_err, data_count, fifo_empty, prog_full);
    end
    m_axis_tready = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (s_axis_tready !== 1'b1 || rd_busy !== 1'b0 || rd_done !== 1'b0 || data_count !== '0) begin
        miscompares++;
        $display("FAIL midburst_recover: tready=%b busy=%b done=%b count=%0d, expected 1/0/0/0", s_axis_tready, rd_busy, rd_done, data_count);
      end
    end
  endtask

`ifdef DATA_FIFO_PROG_FULL_EN
  task automatic burst(int len);
    int n;
    int g;
    n = 0;
    g = 0;
    rd_len = LW'(len);
    rd_req = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    rd_req = 1'b0;
    while (n < len && g < 2000) begin
      if (m_axis_tvalid) n++;
      tick();
      g++;
    end
    m_axis_tready = 1'b0;
    vectors++;
    if (n != len) begin
      miscompares++;
      $display("FAIL burst_timeout: beats=%0d, expected %0d", n, len);
    end
  endtask

  task automatic test_prog_full();
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 16299; i++) begin
      s_axis_tdata = DW'(seq); seq++; tick();
    end
    s_axis_tvalid = 1'b0;
    tick();
    vectors++;
    if (int'(data_count) != 16299 || prog_full !== 1'b0) begin
      miscompares++;
      $display("FAIL pf_below: count=%0d pf=%b, expected 16299/0", data_count, prog_full);
    end
    s_axis_tdata = DW'(seq); seq++; s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    vectors++;
    if (int'(data_count) != 16300 || prog_full !== 1'b0) begin
      miscompares++;
      $display("FAIL pf_lag: count=%0d pf=%b, expected 16300/0", data_count, prog_full);
    end
    tick();
    vectors++;
    if (prog_full !== 1'b1) begin
      miscompares++;
      $display("FAIL pf_set: pf=%b, expected 1", prog_full);
    end
    burst(64);
    repeat (2) tick();
    vectors++;
    if (int'(data_count) != 16236 || prog_full !== 1'b1) begin
      miscompares++;
      $display("FAIL pf_hyst: count=%0d pf=%b, expected 16236/1", data_count, prog_full);
    end
    burst(1);
    repeat (2) tick();
    vectors++;
    if (int'(data_count) != 16235 || prog_full !== 1'b0) begin
      miscompares++;
      $display("FAIL pf_clear: count=%0d pf=%b, expected 16235/0", data_count, prog_full);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_zero_len();
    test_random_burst();
    test_full();
    test_reset_mid_burst();
`ifdef DATA_FIFO_PROG_FULL_EN
    test_prog_full();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
